// File: rtl/tge_tx_packetizer_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tge_tx_packetizer_mc : multi-channel round-robin UDP packetizer that feeds  |
// | the kat_ten_gb_eth tx_* port. TGE_TX_HEADER_EN adds a per-frame header word. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tge_tx_packetizer_mc #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 64,
   parameter int PKT_WORDS  = 128,
   parameter int FIFO_AW    = 9
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       enable,
   input  logic [NUM_CH-1:0]                          ch_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0]               ch_data,
   input  logic [NUM_CH*32-1:0]                       ch_dest_ip,
   input  logic [NUM_CH*16-1:0]                       ch_dest_port,
   input  logic                                       ovf_clear,
   output logic [NUM_CH-1:0]                          ch_overflow,
   output logic                                       tx_valid,
   output logic [DATA_WIDTH-1:0]                      tx_data,
   output logic                                       tx_end_of_frame,
   output logic [31:0]                                tx_dest_ip,
   output logic [15:0]                                tx_dest_port,
   input  logic                                       tx_afull,
   input  logic                                       tx_overflow,
   output logic [31:0]                                pkt_count,
   output logic [15:0]                                core_ovf_count,
   output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] active_ch
);

   localparam int              CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int              DEPTH      = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] CNT_ONE    = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
   localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0] PKT_LEN    = (FIFO_AW+1)'(PKT_WORDS);
   localparam logic [FIFO_AW:0] LAST_IDX   = PKT_LEN - CNT_ONE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
`ifdef TGE_TX_HEADER_EN
      ST_HDR  = 2'd2,
`endif
      ST_DATA = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [CH_W-1:0]        grant;
   logic [CH_W-1:0]        rr_last;
   logic [CH_W-1:0]        pick;
   logic                   found;
   logic                   grant_ld;
   logic                   pop_en;
   logic [FIFO_AW:0]       pop_cnt;
   logic [NUM_CH-1:0]      pop;
   logic [NUM_CH-1:0]      eligible;
   logic [DATA_WIDTH-1:0]  fifo_head [NUM_CH];
   logic [DATA_WIDTH-1:0]  sel_head;
   logic [31:0]            sel_ip;
   logic [15:0]            sel_port;
`ifdef TGE_TX_HEADER_EN
   logic                   hdr_go;
   logic [47:0]            seq [NUM_CH];
`endif

   // Per-channel FIFOs; a write into a full FIFO is still accepted when
   // the same cycle pops it.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [FIFO_AW-1:0]    wr_ptr;
      logic [FIFO_AW-1:0]    rd_ptr;
      logic [FIFO_AW:0]      cnt;
      logic                  wr_ok;
      logic                  ovf;

      assign wr_ok        = ch_valid[i] && ((cnt < FULL_LEVEL) || pop[i]);
      assign fifo_head[i] = mem[rd_ptr];
      assign eligible[i]  = (cnt >= PKT_LEN);
      assign ch_overflow[i] = ovf;

      always_ff @(posedge clk) begin
         if (wr_ok) begin
            mem[wr_ptr] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
         end else begin
            if (wr_ok) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop[i]) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, pop[i]})
               2'b10:   cnt <= cnt + CNT_ONE;
               2'b01:   cnt <= cnt - CNT_ONE;
               default: cnt <= cnt;
            endcase
            if (ch_valid[i] && !wr_ok) begin
               ovf <= 1'b1;
            end else if (ovf_clear) begin
               ovf <= 1'b0;
            end
         end
      end
   end

   // First eligible channel strictly after the last one granted, cyclically.
   always_comb begin
      int idx_i;
      found = 1'b0;
      pick  = '0;
      idx_i = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx_i = int'(rr_last) + k;
         if (idx_i >= NUM_CH) begin
            idx_i = idx_i - NUM_CH;
         end
         if (!found && eligible[CH_W'(idx_i)]) begin
            found = 1'b1;
            pick  = CH_W'(idx_i);
         end
      end
   end

   always_comb begin
      pop      = '0;
      sel_head = '0;
      sel_ip   = '0;
      sel_port = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant == CH_W'(i)) begin
            pop[i]   = pop_en;
            sel_head = fifo_head[i];
            sel_ip   = ch_dest_ip[i*32 +: 32];
            sel_port = ch_dest_port[i*16 +: 16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_ld  = 1'b0;
      pop_en    = 1'b0;
`ifdef TGE_TX_HEADER_EN
      hdr_go    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (enable && found) begin
               grant_ld  = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
`ifdef TGE_TX_HEADER_EN
            state_nxt = ST_HDR;
`else
            state_nxt = ST_DATA;
`endif
         end
`ifdef TGE_TX_HEADER_EN
         ST_HDR: begin
            if (!tx_afull) begin
               hdr_go    = 1'b1;
               state_nxt = ST_DATA;
            end
         end
`endif
         ST_DATA: begin
            if (!tx_afull) begin
               pop_en = 1'b1;
               if (pop_cnt == LAST_IDX) begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output register: the popped head word is presented on the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant           <= '0;
         rr_last         <= CH_W'(NUM_CH - 1);
         pop_cnt         <= '0;
         tx_valid        <= 1'b0;
         tx_data         <= '0;
         tx_end_of_frame <= 1'b0;
         tx_dest_ip      <= '0;
         tx_dest_port    <= '0;
         pkt_count       <= '0;
         active_ch       <= '0;
`ifdef TGE_TX_HEADER_EN
         for (int i = 0; i < NUM_CH; i++) begin
            seq[i] <= '0;
         end
`endif
      end else begin
         tx_valid        <= 1'b0;
         tx_end_of_frame <= 1'b0;
         if (grant_ld) begin
            grant   <= pick;
            rr_last <= pick;
         end
         if (state == ST_LOAD) begin
            tx_dest_ip   <= sel_ip;
            tx_dest_port <= sel_port;
            active_ch    <= grant;
            pop_cnt      <= '0;
         end
`ifdef TGE_TX_HEADER_EN
         if (hdr_go) begin
            tx_valid       <= 1'b1;
            tx_data        <= DATA_WIDTH'({8'(active_ch), 8'h00, seq[active_ch]});
            seq[active_ch] <= seq[active_ch] + 48'd1;
         end
`endif
         if (pop_en) begin
            tx_valid <= 1'b1;
            tx_data  <= sel_head;
            pop_cnt  <= pop_cnt + CNT_ONE;
            if (pop_cnt == LAST_IDX) begin
               tx_end_of_frame <= 1'b1;
               pkt_count       <= pkt_count + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         core_ovf_count <= '0;
      end else if (tx_overflow && (core_ovf_count != 16'hFFFF)) begin
         core_ovf_count <= core_ovf_count + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tge_tx_packetizer_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_tge_tx_packetizer_mc : scoreboard bench for tge_tx_packetizer_mc          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_tge_tx_packetizer_mc;

   localparam int NUM_CH = 4;
   localparam int DW     = 64;
   localparam int PKT    = 8;
   localparam int AW     = 4;
   localparam int DEPTH  = 16;

   logic                 clk = 1'b0;
   logic                 rst, enable, ovf_clear, tx_afull, tx_overflow;
   logic [NUM_CH-1:0]    ch_valid;
   logic [NUM_CH*DW-1:0] ch_data;
   logic [NUM_CH*32-1:0] ch_dest_ip;
   logic [NUM_CH*16-1:0] ch_dest_port;
   logic [NUM_CH-1:0]    ch_overflow;
   logic                 tx_valid, tx_end_of_frame;
   logic [DW-1:0]        tx_data;
   logic [31:0]          tx_dest_ip, pkt_count;
   logic [15:0]          tx_dest_port, core_ovf_count;
   logic [1:0]           active_ch;

   always #5 clk = ~clk;

   tge_tx_packetizer_mc #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .PKT_WORDS(PKT), .FIFO_AW(AW)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .ch_valid(ch_valid), .ch_data(ch_data),
      .ch_dest_ip(ch_dest_ip), .ch_dest_port(ch_dest_port),
      .ovf_clear(ovf_clear), .ch_overflow(ch_overflow),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_end_of_frame(tx_end_of_frame),
      .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port),
      .tx_afull(tx_afull), .tx_overflow(tx_overflow),
      .pkt_count(pkt_count), .core_ovf_count(core_ovf_count), .active_ch(active_ch)
   );

   typedef struct {
      logic [63:0] data;
      logic        eof;
      logic [31:0] ip;
      logic [15:0] port;
      int          ch;
   } exp_t;

   exp_t        expq [$];
   exp_t        mon_e;
   logic [63:0] mq [NUM_CH][$];
   logic [47:0] mseq [NUM_CH];
   logic [3:0]  movf;
   int          m_last;
   int          m_pkt;
   int          words_seen = 0;
   logic        prev_eof = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic [31:0] ip_tab   [NUM_CH] = '{32'h0A000000, 32'h0A000001, 32'h0A000002, 32'h0A000003};
   logic [15:0] port_tab [NUM_CH] = '{16'h1000, 16'h1001, 16'h2710, 16'h1003};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_dest();
      ch_dest_ip   = {ip_tab[3], ip_tab[2], ip_tab[1], ip_tab[0]};
      ch_dest_port = {port_tab[3], port_tab[2], port_tab[1], port_tab[0]};
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         mq[i].delete();
         mseq[i] = '0;
      end
      m_last = NUM_CH - 1;
      m_pkt  = 0;
      movf   = '0;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      enable = 1'b0;
      expq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic push_word(input int ch, input logic [63:0] d, input logic clr);
      logic drop;
      ch_valid  = 4'b0001 << ch;
      ch_data   = {{((NUM_CH-1)*DW){1'b0}}, d} << (ch*DW);
      ovf_clear = clr;
      drop      = (mq[ch].size() >= DEPTH);
      if (!drop) mq[ch].push_back(d);
      for (int i = 0; i < NUM_CH; i++) begin
         if (i == ch && drop) movf[i] = 1'b1;
         else if (clr)        movf[i] = 1'b0;
      end
      @(negedge clk);
      ch_valid  = '0;
      ovf_clear = 1'b0;
   endtask

   task automatic fill(input int ch, input logic [63:0] base, input int n);
      for (int k = 0; k < n; k++) push_word(ch, base + 64'(k), 1'b0);
   endtask

   // Predict arbitration order and frame contents from the model FIFOs.
   task automatic plan_frames(input int n);
      exp_t e;
      for (int f = 0; f < n; f++) begin
         int ch;
         ch = -1;
         for (int k = 1; k <= NUM_CH; k++) begin
            int idx;
            idx = (m_last + k) % NUM_CH;
            if (ch < 0 && mq[idx].size() >= PKT) ch = idx;
         end
         if (ch < 0) return;
         m_last = ch;
         e.ip = ip_tab[ch]; e.port = port_tab[ch]; e.ch = ch;
`ifdef TGE_TX_HEADER_EN
         e.data = {8'(ch), 8'h00, mseq[ch]};
         e.eof  = 1'b0;
         expq.push_back(e);
         mseq[ch] = mseq[ch] + 48'd1;
`endif
         for (int w = 0; w < PKT; w++) begin
            e.data = mq[ch].pop_front();
            e.eof  = (w == PKT - 1);
            expq.push_back(e);
         end
         m_pkt++;
      end
   endtask

   task automatic wait_drain();
      int cyc;
      cyc = 0;
      while (expq.size() != 0 && cyc < 600) begin
         @(negedge clk); #1;
         cyc++;
      end
      enable = 1'b0;
      check("drain_timeout", 64'(cyc < 600), 64'd1);
      repeat (6) @(negedge clk);
      check("pkt_count", 64'(pkt_count), 64'(m_pkt));
   endtask

   task automatic wait_words(input int target, input string tag);
      int cyc;
      cyc = 0;
      while (words_seen < target && cyc < 200) begin
         @(negedge clk); #1;
         cyc++;
      end
      check(tag, 64'(cyc < 200), 64'd1);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_eof = 1'b0;
      end else begin
         if (prev_eof) check("idle_gap", 64'(tx_valid), 64'd0);
         if (tx_valid) begin
            words_seen++;
            if (expq.size() == 0) begin
               check("unexpected_word", 64'(expq.size()), 64'd1);
            end else begin
               mon_e = expq.pop_front();
               check("tx_data", tx_data, mon_e.data);
               check("tx_eof", 64'(tx_end_of_frame), 64'(mon_e.eof));
               check("tx_dest_ip", 64'(tx_dest_ip), 64'(mon_e.ip));
               check("tx_dest_port", 64'(tx_dest_port), 64'(mon_e.port));
               check("active_ch", 64'(active_ch), 64'(mon_e.ch));
            end
         end else begin
            check("eof_without_valid", 64'(tx_end_of_frame), 64'd0);
         end
         prev_eof = tx_valid && tx_end_of_frame;
      end
   end

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, 64'(tx_valid), 64'd0);
      check({tag, "_eof"},   64'(tx_end_of_frame), 64'd0);
      check({tag, "_data"},  tx_data, 64'd0);
      check({tag, "_ip"},    64'(tx_dest_ip), 64'd0);
      check({tag, "_port"},  64'(tx_dest_port), 64'd0);
      check({tag, "_pkt"},   64'(pkt_count), 64'd0);
      check({tag, "_covf"},  64'(core_ovf_count), 64'd0);
      check({tag, "_ach"},   64'(active_ch), 64'd0);
      check({tag, "_chovf"}, 64'(ch_overflow), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, stall_valid;
      rst = 1'b1; enable = 1'b0; ovf_clear = 1'b0; tx_afull = 1'b0; tx_overflow = 1'b0;
      ch_valid = '0; ch_data = '0;
      set_dest();
      model_reset();
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single frame from ch2
      fill(2, 64'h0, 8);
      plan_frames(1);
      enable = 1'b1;
      wait_drain();
      check("t1_dest_ip", 64'(tx_dest_ip), 64'h0A000002);
      check("t1_dest_port", 64'(tx_dest_port), 64'h2710);

      // Round robin across ch0, ch1, ch3
      do_reset();
      fill(0, 64'h1000, 16);
      fill(1, 64'h2000, 16);
      fill(3, 64'h3000, 16);
      plan_frames(6);
      enable = 1'b1;
      wait_drain();

      // Backpressure mid-frame, destination inputs changed during the frame
      fill(2, 64'h4000, 8);
      plan_frames(1);
      base = words_seen;
      enable = 1'b1;
      wait_words(base + 3, "stall_start_timeout");
      tx_afull     = 1'b1;
      ch_dest_ip   = {ip_tab[3], 32'hDEADBEEF, ip_tab[1], ip_tab[0]};
      ch_dest_port = {port_tab[3], 16'hBEEF, port_tab[1], port_tab[0]};
      stall_valid  = 0;
      repeat (5) begin
         @(negedge clk); #1;
         if (tx_valid) stall_valid++;
      end
      check("stall_extra_words", 64'(stall_valid <= 1), 64'd1);
      tx_afull = 1'b0;
      wait_drain();
      set_dest();

      // FIFO full boundary and sticky overflow
      fill(1, 64'h5000, 20);
      check("ovf_set", 64'(ch_overflow), 64'(movf));
      check("ovf_set_ch1", 64'(ch_overflow[1]), 64'd1);
      ovf_clear = 1'b1;
      @(negedge clk);
      ovf_clear = 1'b0;
      movf = '0;
      check("ovf_cleared", 64'(ch_overflow), 64'd0);
      push_word(1, 64'h5FFF, 1'b1);
      check("ovf_set_beats_clear", 64'(ch_overflow), 64'(movf));
      plan_frames(2);
      enable = 1'b1;
      wait_drain();

      // Core overflow counter
      tx_overflow = 1'b1;
      repeat (3) @(negedge clk);
      tx_overflow = 1'b0;
      @(negedge clk);
      check("core_ovf_count", 64'(core_ovf_count), 64'd3);

      // Reset in the middle of a frame
      fill(2, 64'h6000, 8);
      plan_frames(1);
      base = words_seen;
      enable = 1'b1;
      wait_words(base + 4, "rst_word_timeout");
      rst = 1'b1;
      enable = 1'b0;
      expq.delete();
      @(negedge clk); #1;
      check_zero_outputs("midrst");
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      fill(2, 64'h7000, 8);
      fill(0, 64'h8000, 8);
      plan_frames(2);
      enable = 1'b1;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
